mmu_tile_sequencer: RTL
=======================

Name: mmu_tile_sequencer

Overview:
Sequences one output-stationary tile computation on the LENGTH x LENGTH systolic Matrix Multiply Unit. The block:
- clears the PE accumulators;
- streams K_LEN input and weight vectors from the input and weight buffers (generates read enables and addresses);
- keeps the array enabled while the skewed wavefront drains;
- signals DONE.

It sits between the tile-level command issuer and the array, the input/weight buffers and the edge skew registers.

Parameters:
LENGTH, 256, array dimension (rows = columns)
K_WIDTH, 16, width of the inner-dimension length K_LEN
ADDR_WIDTH, 16, buffer read-address width
RD_LATENCY, 1, buffer read latency in cycles (>=1)

Ports:
CLK  input  1  clock, rising edge
ASYNC_RST  input  1  asynchronous reset, active-low
START  input  1  tile command strobe, sampled in IDLE only
ABORT  input  1  cancel current tile
K_LEN  input  K_WIDTH  inner dimension (vectors to stream), latched on START
IN_BASE  input  ADDR_WIDTH  input-buffer start address, latched on START
WT_BASE  input  ADDR_WIDTH  weight-buffer start address, latched on START
BUSY  output  1  high in any state other than IDLE
DONE  output  1  one-cycle pulse, tile results valid in PEs
IN_RD_EN  output  1  input-buffer read enable
IN_RD_ADDR  output  ADDR_WIDTH  input-buffer read address
WT_RD_EN  output  1  weight-buffer read enable
WT_RD_ADDR  output  ADDR_WIDTH  weight-buffer read address
FEED_VALID  output  1  buffer data on edge bus is real (else skew regs inject zero)
ARRAY_EN  output  1  drives array EN
ARRAY_CLR  output  1  drives array SYNC_RST (accumulator clear)
PERF_CYCLES  output  32  busy-cycle count (see Optional Feature)

Behaviour:
- Reset (ASYNC_RST=0), asynchronous at any time including mid-tile:
  - state goes to IDLE;
  - all outputs are 0;
  - all counters and latched registers are 0.
- States: IDLE, CLEAR, FEED, DRAIN, FIN.
- IDLE:
  - START=1 and K_LEN!=0: latch K_LEN, IN_BASE and WT_BASE; go to CLEAR.
  - START=1 and K_LEN==0: go to FIN. The array is not touched.
- START while BUSY is ignored (no queueing).
- CLEAR: 1 cycle; ARRAY_CLR=1, ARRAY_EN=1; then go to FEED.
- FEED: exactly K cycles, feed counter f=0..K-1.
  - IN_RD_EN=WT_RD_EN=1.
  - IN_RD_ADDR=IN_BASE+f and WT_RD_ADDR=WT_BASE+f, modulo 2^ADDR_WIDTH (wrap allowed).
  - ARRAY_EN=1.
  - Then go to DRAIN.
- DRAIN: exactly D = RD_LATENCY + 2*(LENGTH-1) cycles.
  - ARRAY_EN=1; read enables are 0.
  - Addresses hold their last value.
  - Then go to FIN.
- FIN: 1 cycle; DONE=1, ARRAY_EN=0; then go to IDLE.
- FEED_VALID is IN_RD_EN delayed by RD_LATENCY cycles through a shift register. The shift register is cleared by reset and by ABORT.
- Timing, with START sampled at edge 0:
  - CLEAR is cycle 1.
  - FEED is cycles 2..K+1.
  - DRAIN is cycles K+2..K+D+1.
  - DONE is high in cycle K+D+2.
- ABORT, in any non-IDLE state:
  - next cycle: state is IDLE;
  - all outputs 0, FEED_VALID pipeline cleared, no DONE pulse.
- ABORT and START in the same IDLE cycle: ABORT wins, START is ignored.
- ARRAY_CLR is only ever high in CLEAR.
- ARRAY_EN is high in CLEAR, FEED and DRAIN only.

Optional Feature:
Macro MMU_SEQ_PERF_COUNT_EN.
- Defined:
  - PERF_CYCLES counts cycles with BUSY=1.
  - It is cleared to 0 on an accepted START, then counts.
  - It saturates at 2^32-1.
  - It holds its value in IDLE and after ABORT.
  - It resets to 0.
- Not defined: PERF_CYCLES is tied to 0 and the counter logic is absent.

Test Plan:
1. LENGTH=4, RD_LATENCY=1, START with K_LEN=5, IN_BASE=0x10, WT_BASE=0x80 -> ARRAY_CLR high in cycle 1 only. Addresses 0x10..0x14 and 0x80..0x84 in cycles 2..6. FEED_VALID high in cycles 3..7. DONE pulse in cycle 14. BUSY high in cycles 1..14.
2. START with K_LEN=0 -> DONE in cycle 1. ARRAY_EN, ARRAY_CLR and read enables never asserted.
3. IN_BASE=0xFFFE, K_LEN=4 -> IN_RD_ADDR sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
4. ABORT in cycle 4 of test 1 -> cycle 5: IDLE, all outputs 0, FEED_VALID 0, no DONE ever. A following START runs a clean full tile.
5. ASYNC_RST pulled low mid-DRAIN -> outputs 0 immediately, no clock needed. After release, START is accepted normally. START pulses during BUSY are ignored (DONE count = 1).
6. With MMU_SEQ_PERF_COUNT_EN, test 1 -> PERF_CYCLES=14 after DONE, held in IDLE. Without the macro, PERF_CYCLES stays 0.

Source files
------------

// File: rtl/mmu_tile_sequencer.sv
// ============================================================================
// Module   : mmu_tile_sequencer
// Brief    : Runs one output-stationary tile on the systolic MMU: clear, feed K
//            vectors, drain the skewed wavefront, then pulse DONE.
//            Optional busy-cycle counter enabled by macro MMU_SEQ_PERF_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmu_tile_sequencer #(
  parameter int LENGTH     = 256,
  parameter int K_WIDTH    = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  ASYNC_RST,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [K_WIDTH-1:0]    K_LEN,
  input  logic [ADDR_WIDTH-1:0] IN_BASE,
  input  logic [ADDR_WIDTH-1:0] WT_BASE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  IN_RD_EN,
  output logic [ADDR_WIDTH-1:0] IN_RD_ADDR,
  output logic                  WT_RD_EN,
  output logic [ADDR_WIDTH-1:0] WT_RD_ADDR,
  output logic                  FEED_VALID,
  output logic                  ARRAY_EN,
  output logic                  ARRAY_CLR,
  output logic [31:0]           PERF_CYCLES
);

  localparam int c_drain   = RD_LATENCY + 2 * (LENGTH - 1);
  localparam int c_drain_w = $clog2(c_drain + 1);
  localparam int c_cnt_w   = (K_WIDTH > c_drain_w) ? K_WIDTH : c_drain_w;
  localparam logic [c_cnt_w-1:0] c_drain_last = c_cnt_w'(c_drain - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t                r_state;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [c_cnt_w-1:0]    r_k_last;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_in_rd_en;
  logic                  r_wt_rd_en;
  logic [ADDR_WIDTH-1:0] r_in_addr;
  logic [ADDR_WIDTH-1:0] r_wt_addr;
  logic                  r_array_en;
  logic                  r_array_clr;
  logic                  w_feed_valid;

  // All outputs are registered alongside the state so they line up with it.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_k_last    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_in_rd_en  <= 1'b0;
      r_wt_rd_en  <= 1'b0;
      r_in_addr   <= '0;
      r_wt_addr   <= '0;
      r_array_en  <= 1'b0;
      r_array_clr <= 1'b0;
    end else if (ABORT) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_k_last    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_in_rd_en  <= 1'b0;
      r_wt_rd_en  <= 1'b0;
      r_in_addr   <= '0;
      r_wt_addr   <= '0;
      r_array_en  <= 1'b0;
      r_array_clr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_busy <= 1'b1;
            if (K_LEN != '0) begin
              r_k_last    <= c_cnt_w'(K_LEN - K_WIDTH'(1));
              r_in_addr   <= IN_BASE;
              r_wt_addr   <= WT_BASE;
              r_cnt       <= '0;
              r_array_clr <= 1'b1;
              r_array_en  <= 1'b1;
              r_state     <= S_CLEAR;
            end else begin
              // Empty tile: report completion without touching the array.
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end
        S_CLEAR: begin
          r_array_clr <= 1'b0;
          r_in_rd_en  <= 1'b1;
          r_wt_rd_en  <= 1'b1;
          r_state     <= S_FEED;
        end
        S_FEED: begin
          if (r_cnt == r_k_last) begin
            r_in_rd_en <= 1'b0;
            r_wt_rd_en <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_DRAIN;
          end else begin
            r_cnt     <= r_cnt + c_cnt_one;
            r_in_addr <= r_in_addr + ADDR_WIDTH'(1);
            r_wt_addr <= r_wt_addr + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (r_cnt == c_drain_last) begin
            r_array_en <= 1'b0;
            r_done     <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_FIN;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read-enable delayed by the buffer latency marks real data on the edge bus.
  if (RD_LATENCY == 1) begin : g_lat_one
    logic r_pipe;
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
      if (!ASYNC_RST)  r_pipe <= 1'b0;
      else if (ABORT)  r_pipe <= 1'b0;
      else             r_pipe <= r_in_rd_en;
    end
    assign w_feed_valid = r_pipe;
  end else begin : g_lat_multi
    logic [RD_LATENCY-1:0] r_pipe;
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
      if (!ASYNC_RST)  r_pipe <= '0;
      else if (ABORT)  r_pipe <= '0;
      else             r_pipe <= {r_pipe[RD_LATENCY-2:0], r_in_rd_en};
    end
    assign w_feed_valid = r_pipe[RD_LATENCY-1];
  end

`ifdef MMU_SEQ_PERF_COUNT_EN
  logic [31:0] r_perf;
  logic        w_accept;
  assign w_accept = (r_state == S_IDLE) && START && !ABORT;

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST)                      r_perf <= '0;
    else if (w_accept)                   r_perf <= '0;
    else if (r_busy && (r_perf != '1))   r_perf <= r_perf + 32'd1;
  end
  assign PERF_CYCLES = r_perf;
`else
  assign PERF_CYCLES = '0;
`endif

  assign BUSY       = r_busy;
  assign DONE       = r_done;
  assign IN_RD_EN   = r_in_rd_en;
  assign WT_RD_EN   = r_wt_rd_en;
  assign IN_RD_ADDR = r_in_addr;
  assign WT_RD_ADDR = r_wt_addr;
  assign FEED_VALID = w_feed_valid;
  assign ARRAY_EN   = r_array_en;
  assign ARRAY_CLR  = r_array_clr;

endmodule

`default_nettype wire
